// File: rtl/surprise_spawner.sv
// Surprise spawner: decides when a surprise object exists after a brick strike
// and feeds the motion block its enable, spawn position and load strobe.
// Tracks lifetime, collection, off-screen exit, cooldown and per-level budget.
module surprise_spawner #(
   parameter int LIFETIME_FRAMES = 300,
   parameter int COOLDOWN_FRAMES = 90,
   parameter int SPAWN_Y_OFFSET  = 32,
   parameter int MAX_SPAWNS      = 3,
   parameter int SCREEN_BOTTOM   = 479
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               levelRestart,
   input  logic               brickHit,
   input  logic [10:0]        brick_x,
   input  logic [10:0]        brick_y,
   input  logic               collected,
   input  logic signed [10:0] surpriseTopLeftY,
   output logic               enable_out,
   output logic [10:0]        initial_x,
   output logic [10:0]        initial_y,
   output logic               spawn_load,
   output logic               collected_pulse,
   output logic [3:0]         spawns_left
);

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      ACTIVE,
      COOLDOWN,
      EXHAUSTED
   } state_t;

   localparam logic [15:0]        LIFE_INIT  = 16'(LIFETIME_FRAMES);
   localparam logic [15:0]        COOL_INIT  = 16'(COOLDOWN_FRAMES);
   localparam logic [10:0]        Y_OFFSET   = 11'(SPAWN_Y_OFFSET);
   localparam logic [3:0]         SPAWN_INIT = 4'(MAX_SPAWNS);
   localparam logic signed [11:0] BOTTOM_S   = 12'(SCREEN_BOTTOM);

   state_t             state_q;
   logic               enable_q;
   logic               spawn_load_q;
   logic               collected_pulse_q;
   logic [10:0]        initial_x_q;
   logic [10:0]        initial_y_q;
   logic [3:0]         spawns_left_q;
   logic [15:0]        life_q;
   logic [15:0]        cool_q;

   logic [15:0]        life_d;
   logic [15:0]        cool_d;
   logic signed [11:0] surprise_y_ext;
   logic               offscreen;

   // Spawn Y sits above the brick; clamp at the top row instead of wrapping.
   function automatic logic [10:0] sat_spawn_y(input logic [10:0] y);
      if (y < Y_OFFSET) begin
         return 11'd0;
      end
      return y - Y_OFFSET;
   endfunction

   // Frame-counter step that holds at zero rather than wrapping.
   function automatic logic [15:0] sat_dec(input logic [15:0] cnt, input logic step);
      if (step && (cnt != 16'd0)) begin
         return cnt - 16'd1;
      end
      return cnt;
   endfunction

   // Next counter values and off-screen detection for the current cycle.
   always_comb begin
      life_d         = sat_dec(life_q, startOfFrame);
      cool_d         = sat_dec(cool_q, startOfFrame);
      surprise_y_ext = {surpriseTopLeftY[10], surpriseTopLeftY};
      offscreen      = (surprise_y_ext < 12'sd0) || (surprise_y_ext > BOTTOM_S);
   end

   // Spawner FSM with all outputs registered; levelRestart overrides every state.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q           <= IDLE;
         enable_q          <= 1'b0;
         spawn_load_q      <= 1'b0;
         collected_pulse_q <= 1'b0;
         initial_x_q       <= 11'd0;
         initial_y_q       <= 11'd0;
         spawns_left_q     <= SPAWN_INIT;
         life_q            <= 16'd0;
         cool_q            <= 16'd0;
      end else begin
         spawn_load_q      <= 1'b0;
         collected_pulse_q <= 1'b0;
         if (levelRestart) begin
            state_q       <= IDLE;
            enable_q      <= 1'b0;
            spawns_left_q <= SPAWN_INIT;
            life_q        <= 16'd0;
            cool_q        <= 16'd0;
         end else begin
            case (state_q)
               IDLE: begin
                  enable_q <= 1'b0;
                  if (brickHit && (spawns_left_q != 4'd0)) begin
                     initial_x_q   <= brick_x;
                     initial_y_q   <= sat_spawn_y(brick_y);
                     spawns_left_q <= spawns_left_q - 4'd1;
                     state_q       <= SPAWN;
                  end
               end
               SPAWN: begin
                  spawn_load_q <= 1'b1;
                  enable_q     <= 1'b1;
                  life_q       <= LIFE_INIT;
                  state_q      <= ACTIVE;
               end
               ACTIVE: begin
                  if (collected) begin
                     collected_pulse_q <= 1'b1;
                     enable_q          <= 1'b0;
                     cool_q            <= COOL_INIT;
                     state_q           <= COOLDOWN;
                  end else if (offscreen || (life_d == 16'd0)) begin
                     enable_q <= 1'b0;
                     life_q   <= life_d;
                     cool_q   <= COOL_INIT;
                     state_q  <= COOLDOWN;
                  end else begin
                     life_q <= life_d;
                  end
               end
               COOLDOWN: begin
                  enable_q <= 1'b0;
                  cool_q   <= cool_d;
                  if (cool_d == 16'd0) begin
                     state_q <= (spawns_left_q != 4'd0) ? IDLE : EXHAUSTED;
                  end
               end
               EXHAUSTED: begin
                  enable_q <= 1'b0;
               end
               default: begin
                  enable_q <= 1'b0;
                  state_q  <= IDLE;
               end
            endcase
         end
      end
   end

   assign enable_out      = enable_q;
   assign initial_x       = initial_x_q;
   assign initial_y       = initial_y_q;
   assign spawn_load      = spawn_load_q;
   assign collected_pulse = collected_pulse_q;
   assign spawns_left     = spawns_left_q;

endmodule

// File: tb/tb_surprise_spawner.sv
// Scoreboard bench for surprise_spawner: directed stimulus pushes expected
// spawn/collection events; a negedge monitor pops and compares them.
module tb_surprise_spawner;

   logic               clk = 1'b0;
   logic               resetN;
   logic               startOfFrame;
   logic               levelRestart;
   logic               brickHit;
   logic [10:0]        brick_x;
   logic [10:0]        brick_y;
   logic               collected;
   logic signed [10:0] surpriseTopLeftY;
   logic               enable_out;
   logic [10:0]        initial_x;
   logic [10:0]        initial_y;
   logic               spawn_load;
   logic               collected_pulse;
   logic [3:0]         spawns_left;

   typedef struct {
      logic [10:0] x;
      logic [10:0] y;
      logic [3:0]  left;
   } spawn_exp_t;

   spawn_exp_t exp_spawn_q[$];
   int         exp_pulse_q[$];
   int         vectors = 0;
   int         fails   = 0;
   int         exp_left;

   surprise_spawner dut (
      .clk              (clk),
      .resetN           (resetN),
      .startOfFrame     (startOfFrame),
      .levelRestart     (levelRestart),
      .brickHit         (brickHit),
      .brick_x          (brick_x),
      .brick_y          (brick_y),
      .collected        (collected),
      .surpriseTopLeftY (surpriseTopLeftY),
      .enable_out       (enable_out),
      .initial_x        (initial_x),
      .initial_y        (initial_y),
      .spawn_load       (spawn_load),
      .collected_pulse  (collected_pulse),
      .spawns_left      (spawns_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
         tick();
      end
   endtask

   // Accepted strike: expects spawn_load exactly two cycles after the hit.
   task automatic do_spawn(input logic [10:0] x, input logic [10:0] y, input logic [10:0] ey);
      spawn_exp_t e;
      exp_left = exp_left - 1;
      e.x = x; e.y = ey; e.left = 4'(exp_left);
      exp_spawn_q.push_back(e);
      brickHit = 1'b1; brick_x = x; brick_y = y;
      tick();
      brickHit = 1'b0;
      check("lat_load_early", 32'(spawn_load), 32'd0);
      tick();
      check("lat_load", 32'(spawn_load), 32'd1);
      check("lat_enable", 32'(enable_out), 32'd1);
      check("spawns_left", 32'(spawns_left), 32'(exp_left));
      tick();
      check("load_one_cycle", 32'(spawn_load), 32'd0);
   endtask

   // Strike that must be ignored; any spawn_load is flagged by the monitor.
   task automatic hit_only(input logic [10:0] x, input logic [10:0] y);
      brickHit = 1'b1; brick_x = x; brick_y = y;
      tick();
      brickHit = 1'b0;
      tick();
      tick();
   endtask

   // Monitor: every output event must match the head of its expectation queue.
   always @(negedge clk) begin
      if (spawn_load) begin
         if (exp_spawn_q.size() == 0) begin
            check("spawn_unexpected", 32'd1, 32'd0);
         end else begin
            spawn_exp_t e;
            e = exp_spawn_q.pop_front();
            check("mon_initial_x", 32'(initial_x), 32'(e.x));
            check("mon_initial_y", 32'(initial_y), 32'(e.y));
            check("mon_spawns_left", 32'(spawns_left), 32'(e.left));
            check("mon_enable_at_load", 32'(enable_out), 32'd1);
         end
      end
      if (collected_pulse) begin
         if (exp_pulse_q.size() == 0) begin
            check("pulse_unexpected", 32'd1, 32'd0);
         end else begin
            void'(exp_pulse_q.pop_front());
            check("mon_enable_at_pulse", 32'(enable_out), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; levelRestart = 1'b0; brickHit = 1'b0;
      brick_x = '0; brick_y = '0; collected = 1'b0; surpriseTopLeftY = 11'sd100;
      exp_left = 3;
      repeat (2) @(posedge clk);
      #1;
      check("rst_enable", 32'(enable_out), 32'd0);
      check("rst_load", 32'(spawn_load), 32'd0);
      check("rst_pulse", 32'(collected_pulse), 32'd0);
      check("rst_x", 32'(initial_x), 32'd0);
      check("rst_y", 32'(initial_y), 32'd0);
      check("rst_left", 32'(spawns_left), 32'd3);
      resetN = 1'b1;
      tick();

      // Basic spawn then collection held for several cycles
      do_spawn(11'd200, 11'd300, 11'd268);
      exp_pulse_q.push_back(1);
      collected = 1'b1;
      tick();
      check("col_enable_drop", 32'(enable_out), 32'd0);
      check("col_pulse", 32'(collected_pulse), 32'd1);
      repeat (4) tick();
      collected = 1'b0;
      tick();
      check("col_pulse_gone", 32'(collected_pulse), 32'd0);
      check("col_left", 32'(spawns_left), 32'd2);
      frames(90);

      // Saturated Y, lifetime expiry and cooldown boundary
      do_spawn(11'd50, 11'd10, 11'd0);
      frames(299);
      check("life_299_alive", 32'(enable_out), 32'd1);
      frames(1);
      check("life_300_expired", 32'(enable_out), 32'd0);
      check("life_no_pulse", 32'(collected_pulse), 32'd0);
      frames(89);
      hit_only(11'd400, 11'd400);
      check("cool_hit_left", 32'(spawns_left), 32'd1);
      frames(1);
      do_spawn(11'd120, 11'd200, 11'd168);

      // Off-screen exit and ignored strikes, then exhaustion
      hit_only(11'd10, 11'd100);
      check("active_hit_enable", 32'(enable_out), 32'd1);
      check("active_hit_x_hold", 32'(initial_x), 32'd120);
      check("active_hit_left", 32'(spawns_left), 32'd0);
      surpriseTopLeftY = 11'sd480;
      tick();
      surpriseTopLeftY = 11'sd100;
      check("offscreen_enable", 32'(enable_out), 32'd0);
      tick();
      check("offscreen_no_pulse", 32'(collected_pulse), 32'd0);
      hit_only(11'd20, 11'd100);
      frames(90);
      hit_only(11'd30, 11'd100);
      check("exhausted_left", 32'(spawns_left), 32'd0);
      check("exhausted_enable", 32'(enable_out), 32'd0);
      levelRestart = 1'b1;
      tick();
      levelRestart = 1'b0;
      check("restart_left", 32'(spawns_left), 32'd3);
      exp_left = 3;

      // Collection coinciding with the final lifetime frame
      do_spawn(11'd300, 11'd40, 11'd8);
      frames(299);
      exp_pulse_q.push_back(1);
      startOfFrame = 1'b1; collected = 1'b1;
      tick();
      startOfFrame = 1'b0; collected = 1'b0;
      check("colife_pulse", 32'(collected_pulse), 32'd1);
      check("colife_enable", 32'(enable_out), 32'd0);
      tick();
      check("colife_single", 32'(collected_pulse), 32'd0);
      frames(90);

      // Asynchronous reset in ACTIVE
      do_spawn(11'd500, 11'd600, 11'd568);
      frames(3);
      #2 resetN = 1'b0;
      #1;
      check("async_enable", 32'(enable_out), 32'd0);
      check("async_x", 32'(initial_x), 32'd0);
      check("async_y", 32'(initial_y), 32'd0);
      check("async_left", 32'(spawns_left), 32'd3);
      exp_left = 3;
      tick();
      resetN = 1'b1;
      tick();

      // levelRestart with simultaneous collection
      do_spawn(11'd700, 11'd31, 11'd0);
      levelRestart = 1'b1; collected = 1'b1;
      tick();
      levelRestart = 1'b0; collected = 1'b0;
      check("lr_col_enable", 32'(enable_out), 32'd0);
      check("lr_col_no_pulse", 32'(collected_pulse), 32'd0);
      check("lr_col_left", 32'(spawns_left), 32'd3);
      exp_left = 3;
      tick();
      check("lr_col_no_pulse2", 32'(collected_pulse), 32'd0);
      do_spawn(11'd64, 11'd32, 11'd0);

      // Negative Y counts as off-screen
      surpriseTopLeftY = -11'sd5;
      tick();
      surpriseTopLeftY = 11'sd100;
      check("neg_y_enable", 32'(enable_out), 32'd0);
      tick();
      check("neg_y_no_pulse", 32'(collected_pulse), 32'd0);

      check("spawn_q_drained", 32'(exp_spawn_q.size()), 32'd0);
      check("pulse_q_drained", 32'(exp_pulse_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/surprise_spawner.md
Name: surprise_spawner

Overview:
Upstream stage of the surprise-object motion block. Watches for the player striking a surprise brick from below and decides when a surprise exists. Supplies the motion block's enable, initial X/Y and a one-cycle load strobe. Tracks lifetime, collection, off-screen exit, cooldown and a per-level spawn budget.

Parameters:
LIFETIME_FRAMES, 300, frames a spawned surprise stays alive if never collected
COOLDOWN_FRAMES, 90, frames after despawn before a new spawn is accepted
SPAWN_Y_OFFSET, 32, pixels above brick top-left where the surprise appears
MAX_SPAWNS, 3, spawns allowed per level (1..15)
SCREEN_BOTTOM, 479, last visible row; surprise topLeftY beyond this is off-screen

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per frame (30 Hz)
levelRestart  in  1  sync pulse; clears spawn budget, returns to IDLE
brickHit  in  1  one-cycle pulse; player head hit a surprise brick
brick_x  in  11  brick top-left X, sampled with brickHit
brick_y  in  11  brick top-left Y, sampled with brickHit
collected  in  1  player/surprise collision (level, any cycle)
surpriseTopLeftY  in  11 signed  current Y from the motion block
enable_out  out  1  surprise exists; drives the motion block's enable
initial_x  out  11  spawn X for the motion block
initial_y  out  11  spawn Y for the motion block
spawn_load  out  1  one-cycle strobe: motion block loads initial_x/y
collected_pulse  out  1  one-cycle pulse to score logic on collection
spawns_left  out  4  remaining spawns this level

Behaviour:
- Reset (resetN=0, async): state IDLE; enable_out=0, spawn_load=0, collected_pulse=0, initial_x=0, initial_y=0, spawns_left=MAX_SPAWNS; all counters 0.
- States: IDLE, SPAWN, ACTIVE, COOLDOWN, EXHAUSTED. All outputs registered.
- IDLE: enable_out=0.
  - brickHit with spawns_left>0: latch initial_x=brick_x.
  - Latch initial_y=brick_y-SPAWN_Y_OFFSET, saturated to 0 if negative.
  - Decrement spawns_left; next state SPAWN.
  - brickHit with spawns_left=0: ignored.
- SPAWN, exactly 1 cycle: spawn_load=1, enable_out=1.
  - Load life counter with LIFETIME_FRAMES; next state ACTIVE.
  - Latency: brickHit at cycle N gives spawn_load and enable_out high at N+2.
- ACTIVE: enable_out=1. Each startOfFrame decrements the life counter.
- ACTIVE exit priority, highest first:
  - collected=1: collected_pulse=1 for 1 cycle, go COOLDOWN.
  - surpriseTopLeftY>SCREEN_BOTTOM or <0: go COOLDOWN, no pulse.
  - Life counter reaches 0: go COOLDOWN, no pulse.
  - While ACTIVE, brickHit is ignored and initial_x/y hold.
- COOLDOWN: enable_out=0. Load cooldown counter with COOLDOWN_FRAMES on entry; decrement per startOfFrame.
  - At 0: go IDLE if spawns_left>0, else EXHAUSTED.
  - brickHit is ignored.
- EXHAUSTED: enable_out=0; only levelRestart leaves.
- levelRestart, from any state, priority over everything: next cycle state IDLE, enable_out=0, spawns_left=MAX_SPAWNS, counters cleared. No collected_pulse, even with simultaneous collected.
- collected outside ACTIVE: ignored. Only one collected_pulse per spawn, even if collected stays high.
- Counters are 16-bit unsigned and never wrap below 0.
- startOfFrame coinciding with a state entry does not count toward the new state's counter.

Test Plan:
1. Reset, brickHit at brick_x=200, brick_y=300 -> two cycles later spawn_load=1 for 1 cycle, initial_x=200, initial_y=268, enable_out=1, spawns_left=2.
2. brickHit with brick_y=10 -> initial_y=0 (saturation). Then 300 startOfFrame pulses with no collection -> enable_out falls after the 300th; 90 more frames -> IDLE; new brickHit accepted.
3. ACTIVE, collected held high 5 cycles -> single-cycle collected_pulse, enable_out=0 next cycle. Collected and life=0 in the same cycle -> still exactly one collected_pulse.
4. ACTIVE, surpriseTopLeftY=480 -> COOLDOWN, no collected_pulse. Extra brickHit during ACTIVE/COOLDOWN -> no spawn_load, spawns_left unchanged.
5. Three full spawn/collect/cooldown cycles -> spawns_left=0, EXHAUSTED; brickHit ignored. levelRestart -> spawns_left=3, next brickHit spawns.
6. Assert resetN low mid-ACTIVE -> outputs immediately at reset values. levelRestart and collected in the same cycle -> no pulse, state IDLE.
